// File: rtl/mini_bit_pkg.sv
// rtl/mini_bit_pkg.sv - shared transmitter state encoding and frame constants
// Optional feature macro: OUT_PORT_UART_PARITY_EN (adds PARITY state, 11-bit frame).
package mini_bit_pkg;

`ifdef OUT_PORT_UART_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam int FRAME_BITS = 11;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam int FRAME_BITS = 10;
`endif

    localparam int DATA_BITS = 8;

endpackage

// File: rtl/out_port_fifo.sv
// rtl/out_port_fifo.sv - byte queue between the mini_bit strobe and the transmitter
// Ports: clk, reg_clear_n (async active-low), push/push_data, pop,
//        head (oldest entry, read from the storage flops), full, empty.
// A push while full is taken only when a pop happens in the same cycle.
module out_port_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 8
) (
    input  logic             clk,
    input  logic             reg_clear_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB separates full from empty when the index bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reg_clear_n) begin
        if (!reg_clear_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/out_port_uart.sv
// rtl/out_port_uart.sv - mini_bit output port: queued bytes sent as async serial frames
// Ports: clk, reg_clear_n (async active-low), bus[7:0] + tx strobe (rising edge enqueues),
//        serial_out (idle high, registered), busy, full, overflow (sticky drop flag).
// Optional feature macro: OUT_PORT_UART_PARITY_EN (even parity bit between data and stop).
module out_port_uart
    import mini_bit_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reg_clear_n,
    input  logic [7:0] bus,
    input  logic       tx,
    output logic       serial_out,
    output logic       busy,
    output logic       full,
    output logic       overflow
);

    localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);

    tx_state_t  state;
    tx_state_t  state_next;
    logic [7:0] baud;
    logic [2:0] bit_idx;
    logic [7:0] shift_data;
    logic       tx_q;
    logic       tx_rise;
    logic       busy_q;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] head;
    logic       bit_last;
    logic       line_bit;

    assign tx_rise  = tx && !tx_q;
    assign bit_last = (baud == BAUD_LAST);
    assign full     = fifo_full;
    // busy_q holds busy for the cycle serial_out still shows the stop bit.
    assign busy     = (state != ST_IDLE) || busy_q || !fifo_empty;

    out_port_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (8)
    ) u_fifo (
        .clk         (clk),
        .reg_clear_n (reg_clear_n),
        .push        (tx_rise),
        .push_data   (bus),
        .pop         (pop),
        .head        (head),
        .full        (fifo_full),
        .empty       (fifo_empty)
    );

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (bit_last) state_next = ST_DATA;
            end
            ST_DATA: begin
                if (bit_last && (bit_idx == 3'd7)) begin
`ifdef OUT_PORT_UART_PARITY_EN
                    state_next = ST_PARITY;
`else
                    state_next = ST_STOP;
`endif
                end
            end
`ifdef OUT_PORT_UART_PARITY_EN
            ST_PARITY: begin
                if (bit_last) state_next = ST_STOP;
            end
`endif
            ST_STOP: begin
                // Chain straight into the next frame so the line has no idle gap.
                if (bit_last) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        line_bit = 1'b1;
        unique case (state)
            ST_START:  line_bit = 1'b0;
            ST_DATA:   line_bit = shift_data[bit_idx];
`ifdef OUT_PORT_UART_PARITY_EN
            ST_PARITY: line_bit = ^shift_data;
`endif
            default:   line_bit = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reg_clear_n) begin
        if (!reg_clear_n) begin
            state      <= ST_IDLE;
            baud       <= 8'd0;
            bit_idx    <= 3'd0;
            shift_data <= 8'd0;
            tx_q       <= 1'b0;
            busy_q     <= 1'b0;
            overflow   <= 1'b0;
            serial_out <= 1'b1;
        end else begin
            state      <= state_next;
            tx_q       <= tx;
            busy_q     <= (state != ST_IDLE);
            serial_out <= line_bit;
            if ((state_next != state) || (state == ST_IDLE) || bit_last) begin
                baud <= 8'd0;
            end else begin
                baud <= baud + 8'd1;
            end
            if ((state == ST_DATA) && bit_last) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (pop) begin
                shift_data <= head;
            end
            if (tx_rise && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: doc/out_port_uart.md
OUT_PORT_UART -- requirements
Module: out_port_uart

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4: clk cycles per serial bit, legal range 2..255.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: byte-queue depth, a power of two, 2..16.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reg_clear_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port bus, input, 8 bits: mini_bit data bus, sampled when a tx strobe is detected.
REQ-006 SHALL have port tx, input, 1 bit: output-instruction strobe from mini_bit; level signal, may stay high several cycles.
REQ-007 SHALL have port serial_out, output, 1 bit: asynchronous serial line, idle high.
REQ-008 SHALL have port busy, output, 1 bit: high while a frame is shifting or the queue is non-empty.
REQ-009 SHALL have port full, output, 1 bit: queue holds FIFO_DEPTH bytes.
REQ-010 SHALL have port overflow, output, 1 bit: sticky; set when a byte is dropped.

Function
REQ-011 SHALL detect a tx rising edge as tx=1 in the current cycle and tx=0 in the previous registered sample; one byte is enqueued per edge.
REQ-012 SHALL write bus into the queue on the clk edge that detects the tx rise; a tx held high SHALL NOT enqueue further bytes.
REQ-013 SHALL drop the byte and set overflow when a tx rise arrives while full=1 and no dequeue occurs in the same cycle.
REQ-014 SHALL allow an enqueue and a dequeue in the same cycle when full=1; the byte is accepted and overflow is not set.
REQ-015 SHALL use a transmitter FSM with states IDLE, START, DATA, STOP (plus PARITY when enabled).
REQ-016 IDLE: serial_out=1; when the queue is non-empty, dequeue the head into the shift register and go to START on the next edge.
REQ-017 START: serial_out=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-018 DATA: send 8 bits LSB first, each for CLKS_PER_BIT cycles, using a 3-bit bit index that wraps 7->0, then go to STOP.
REQ-019 STOP: serial_out=1 for CLKS_PER_BIT cycles, then go to IDLE; there is no extra idle gap when the queue is non-empty.
REQ-020 SHALL make serial_out show the start bit 2 cycles after the clk edge that enqueues into an empty queue in IDLE.
REQ-021 SHALL use a baud counter that counts 0..CLKS_PER_BIT-1 and reloads to 0 on every state change.
REQ-022 SHALL use queue pointers of width log2(FIFO_DEPTH)+1; full and empty are derived from the pointer MSB and the equality of the remaining bits, so wrap-around needs no special case.
REQ-023 SHALL drive serial_out from a register with no combinational path from its inputs.

Reset
REQ-024 SHALL, while reg_clear_n=0, force regardless of clk: FSM=IDLE, serial_out=1, busy=0, full=0, overflow=0, pointers=0, baud counter=0, tx history=0.
REQ-025 SHALL abort any in-flight frame when reset asserts mid-frame; the line returns high immediately and queued bytes are discarded.
REQ-026 SHALL treat tx held high across reset release as having been low before release, so it enqueues once.

Configuration
REQ-027 SHALL support macro OUT_PORT_UART_PARITY_EN: when defined, a PARITY state sits between DATA and STOP and sends the even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles; when undefined, the frame is 8N1 and the PARITY state does not exist.

Structure
REQ-028 SHALL place the FSM state encoding typedef and the frame-length constants (10 bits, or 11 bits with parity) in shared package mini_bit_pkg.
REQ-029 SHALL implement the queue as sub-module out_port_fifo (parameter FIFO_DEPTH, width 8), with push/pop/full/empty and a registered head.

Verification
REQ-030 Reset then one tx pulse with bus=8'hA5, CLKS_PER_BIT=4 -> serial_out = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; busy falls after the stop bit.
REQ-031 tx held high 20 cycles with bus=8'h3C -> exactly one frame is sent.
REQ-032 Five tx pulses one cycle apart while busy, FIFO_DEPTH=4 -> the first byte is sent at once and 4 are queued with no drop and overflow=0; a sixth pulse while full -> overflow=1 and the sixth byte never appears.
REQ-033 Enqueue while full in the same cycle the FSM dequeues -> the byte is accepted and overflow stays 0.
REQ-034 Assert reg_clear_n=0 during DATA bit 3 -> serial_out=1 at once, the queue is empty, and the next tx starts a clean frame.
REQ-035 Build with OUT_PORT_UART_PARITY_EN and send bus=8'h07 -> parity bit is 1 and the frame is 11 bits.
